hansen_icache: RTL and testbench
================================

Name: hansen_icache

Overview:
Direct-mapped, read-only instruction cache between the Hansen core's fetch port (imem_addr/imem_rdata) and a slower line-burst backing memory. A hit returns the instruction combinationally in the same cycle. A miss raises stall, fetches the whole line as a burst, then serves the fetch. A flush input invalidates all lines (fence.i / program reload).

Parameters:
LINES, 16, number of cache lines; power of two, >= 2
WORDS, 4, 32-bit words per line; power of two, >= 2
MISS_CNT_W, 16, width of the saturating miss counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  32  fetch byte address (core PC); bits [1:0] ignored
cpu_rdata  out  32  instruction word; valid only when cpu_hit=1
cpu_hit  out  1  combinational: cpu_addr hits a valid line and state is IDLE
cpu_stall  out  1  fetch not served this cycle; core must hold cpu_addr and PC
flush  in  1  one-cycle pulse: invalidate all lines
mem_req  out  1  refill request; held until accepted
mem_addr  out  32  line-aligned refill address (low log2(WORDS)+2 bits zero)
mem_ack  in  1  memory accepts request this cycle
mem_rvalid  in  1  one refill data beat present
mem_rdata  in  32  refill data beat
miss_count  out  MISS_CNT_W  saturating count of misses since reset

Behaviour:
- Address split:
  - offset = cpu_addr[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - data array LINES*WORDS x 32, tag array LINES x tag width, valid bit per line.
  - Only valid bits and control state are reset; data and tags are not reset.
- Reset (async, reset_n=0):
  - state=IDLE, all valid=0, mem_req=0, mem_addr=0, beat counter=0, miss_count=0, flush_pending=0.
  - cpu_hit=0 (all lines invalid), so cpu_stall=1 while cpu_addr misses. cpu_rdata is don't-care.
- Hit (state IDLE, valid[index] and tag match): cpu_hit=1, cpu_stall=0, cpu_rdata=data[index][offset], zero cycles added.
- cpu_stall = !cpu_hit at all times.
- FSM states: IDLE, REQ, FILL.
  - IDLE, miss and flush=0: latch line address and index; set mem_req=1 with mem_addr; go to REQ; miss_count+1, saturating at all-ones.
  - REQ: mem_req and mem_addr held stable. On mem_ack: drop mem_req next cycle, beat counter=0, go to FILL. mem_ack while mem_req=0 is ignored.
  - FILL: on each mem_rvalid, write mem_rdata to data[latched index][beat] and increment beat.
    - Beats arrive word 0 first, in order.
    - After beat WORDS-1: write tag, set valid unless flush_pending, clear flush_pending, go to IDLE.
    - mem_rvalid in IDLE or REQ is ignored.
- Miss latency: with mem_ack in the cycle after mem_req rises and back-to-back beats, cpu_hit asserts WORDS+3 cycles after the miss cycle.
  - The first IDLE cycle after the fill re-evaluates cpu_addr; it hits if cpu_addr is unchanged.
- cpu_addr changing during REQ/FILL (legal only after reset or a redirect): the refill in progress completes for the latched line, then IDLE re-evaluates the new address.
- Flush:
  - In IDLE: all valid bits cleared at the edge; no refill is started that cycle even on a miss.
  - In REQ/FILL: all valid bits cleared and flush_pending=1. The refill completes but the filled line is left invalid, so the next access misses again.
- The line being refilled never reports a hit before its last beat is written.
- Reset mid-refill aborts immediately: mem_req=0, state=IDLE. Backing memory is reset from the same reset_n, so no stray beats follow.
- No write path: stores to instruction memory are coherent only via flush.

Decomposition:
- Package hansen_icache_pkg holds:
  - state encoding constants (IDLE, REQ, FILL)
  - derived widths OFFSET_W, INDEX_W, TAG_W as localparam functions of LINES/WORDS
  - line-address helper
- One natural sub-module: hansen_icache_data, a data+tag storage array.
  - Async read on index/offset.
  - Synchronous write port for the beat write and the tag write.
  - The FSM, valid bits and counters stay in the top.

Test Plan:
- Reset then cpu_addr=0x0 → cpu_hit=0, cpu_stall=1, mem_req=1 with mem_addr=0x0. Ack on next cycle, 4 beats 0x11,0x22,0x33,0x44 → cpu_hit=1, cpu_rdata=0x11 at cycle 7 after the miss; miss_count=1.
- After that fill, cpu_addr=0x8 → cpu_hit=1, cpu_rdata=0x33 same cycle, no mem_req.
- Conflict: cpu_addr=0x100 (same index 0, different tag) → miss, mem_addr=0x100, refill. Then 0x0 misses again; miss_count=3.
- mem_ack delayed 5 cycles → mem_req and mem_addr stable throughout. A mem_rvalid pulse during REQ is ignored; data is written only from the subsequent FILL beats.
- flush pulsed during FILL beat 2 of line 0x40 → fill completes, cpu_hit stays 0, a new mem_req for 0x40 issues. Previously valid line 0x0 also misses.
- reset_n low during FILL beat 1 → mem_req=0, miss_count=0 immediately (async). After release, the same address misses and refills cleanly.
- Drive miss_count to all-ones with repeated conflict misses → the counter holds at 0xFFFF.

Source files
------------

// File: rtl/hansen_icache_pkg.sv
// Shared types and width helpers for the Hansen instruction cache.
// Widths are derived from LINES/WORDS so every file splits addresses identically.
package hansen_icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic int calc_offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int lines, input int words);
        return 32 - $clog2(lines) - $clog2(words) - 2;
    endfunction

    // Clears the word-offset and byte bits so the address points at the line start.
    function automatic logic [31:0] line_addr(input logic [31:0] addr, input int words);
        logic [31:0] mask;
        mask = (32'd1 << ($clog2(words) + 2)) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/hansen_icache_data.sv
// Data and tag storage for the instruction cache: async read, sync write.
// Contents are never reset; line validity is tracked by the controller.
module hansen_icache_data #(
    parameter int LINES    = 16,
    parameter int WORDS    = 4,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 24
) (
    input  logic                clk,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [31:0]         rd_data,
    output logic [TAG_W-1:0]    rd_tag,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    wr_tag
);

    logic [31:0]      data_mem [LINES*WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];

    assign rd_data = data_mem[{rd_index, rd_offset}];
    assign rd_tag  = tag_mem[rd_index];

    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[{wr_index, wr_offset}] <= wr_data;
        if (tag_we)
            tag_mem[wr_index] <= wr_tag;
    end

endmodule

// File: rtl/hansen_icache.sv
// Direct-mapped read-only instruction cache with whole-line burst refill.
// Hits are combinational in IDLE; a miss stalls the core until the line is filled.
module hansen_icache
    import hansen_icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int WORDS      = 4,
    parameter int MISS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cpu_addr,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_hit,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic [MISS_CNT_W-1:0] miss_count
);

    localparam int OFFSET_W = calc_offset_w(WORDS);
    localparam int INDEX_W  = calc_index_w(LINES);
    localparam int TAG_W    = calc_tag_w(LINES, WORDS);
    localparam int LINE_LSB = OFFSET_W + 2;

    state_t               state, state_nxt;
    logic [LINES-1:0]     valid;
    logic [OFFSET_W-1:0]  beat;
    logic                 flush_pending;

    logic [OFFSET_W-1:0]  offset;
    logic [INDEX_W-1:0]   index, fill_index;
    logic [TAG_W-1:0]     tag, fill_tag, stored_tag;
    logic                 start_miss, beat_wr, last_beat;
    logic [1:0]           unused_addr_bits;

    assign unused_addr_bits = cpu_addr[1:0];
    assign offset = cpu_addr[LINE_LSB-1:2];
    assign index  = cpu_addr[LINE_LSB+INDEX_W-1:LINE_LSB];
    assign tag    = cpu_addr[31:LINE_LSB+INDEX_W];

    // mem_addr stays at the latched line for the whole refill, so it doubles as the fill target.
    assign fill_index = mem_addr[LINE_LSB+INDEX_W-1:LINE_LSB];
    assign fill_tag   = mem_addr[31:LINE_LSB+INDEX_W];

    assign cpu_hit    = (state == IDLE) && valid[index] && (stored_tag == tag);
    assign cpu_stall  = !cpu_hit;
    assign start_miss = (state == IDLE) && !cpu_hit && !flush;
    assign beat_wr    = (state == FILL) && mem_rvalid;
    assign last_beat  = beat_wr && (beat == OFFSET_W'(WORDS - 1));

    hansen_icache_data #(
        .LINES    (LINES),
        .WORDS    (WORDS),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_data (
        .clk       (clk),
        .rd_index  (index),
        .rd_offset (offset),
        .rd_data   (cpu_rdata),
        .rd_tag    (stored_tag),
        .wr_en     (beat_wr),
        .wr_index  (fill_index),
        .wr_offset (beat),
        .wr_data   (mem_rdata),
        .tag_we    (last_beat),
        .wr_tag    (fill_tag)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_miss) state_nxt = REQ;
            REQ:     if (mem_ack)    state_nxt = FILL;
            FILL:    if (last_beat)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            valid         <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            beat          <= '0;
            miss_count    <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start_miss) begin
                    mem_req      <= 1'b1;
                    mem_addr     <= line_addr(cpu_addr, WORDS);
                    valid[index] <= 1'b0;
                    if (miss_count != '1)
                        miss_count <= miss_count + MISS_CNT_W'(1);
                end
                REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    beat    <= '0;
                end
                FILL: if (mem_rvalid) begin
                    beat <= beat + OFFSET_W'(1);
                    if (last_beat) begin
                        valid[fill_index] <= !flush_pending;
                        flush_pending     <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A flush landing on the final beat still wins: the whole vector is cleared last.
            if (flush)
                valid <= '0;
            if (flush && (state != IDLE) && !last_beat)
                flush_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hansen_icache.sv
// Directed bench for hansen_icache: hit/miss timing, conflicts, delayed ack,
// flush during refill, async reset mid-refill and miss-counter saturation.
module tb_hansen_icache;

    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_rdata;
    logic          cpu_hit, cpu_stall;
    logic          flush;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack, mem_rvalid;
    logic [31:0]   mem_rdata;
    logic [MW-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    hansen_icache #(.LINES(16), .WORDS(4), .MISS_CNT_W(MW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_hit    (cpu_hit),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the miss cycle; returns in the first IDLE cycle after the last beat.
    task automatic refill(input logic [31:0] a, input logic [127:0] line, input int ack_delay,
                          input bit junk, input int flush_beat, input bit exp_hit);
        tick();
        chk("req_rise", mem_req, 1);
        chk("req_addr", mem_addr, a);
        tick();
        for (int i = 0; i < ack_delay; i++) begin
            mem_rvalid = junk;
            mem_rdata  = 32'hDEAD_BEEF;
            #1;
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, a);
            tick();
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int w = 0; w < 4; w++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = line[32*w +: 32];
            flush      = (w == flush_beat);
            #1;
            chk("no_early_hit", cpu_hit, 0);
            if (w == 0) chk("req_drop", mem_req, 0);
            tick();
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        #1;
        chk("fill_hit", cpu_hit, exp_hit);
        chk("fill_stall", cpu_stall, !exp_hit);
    endtask

    initial begin
        reset_n    = 1'b0;
        cpu_addr   = 32'h0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cnt", miss_count, 0);
        chk("rst_hit", cpu_hit, 0);
        chk("rst_stall", cpu_stall, 1);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("idle_miss", cpu_hit, 0);
        chk("idle_noreq", mem_req, 0);

        // Cold miss on 0x0, hit 7 cycles later
        refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, -1, 1);
        chk("rdata_0", cpu_rdata, 32'h11);
        chk("cnt_1", miss_count, 1);

        cpu_addr = 32'h8;
        #1;
        chk("hit_8", cpu_hit, 1);
        chk("rdata_8", cpu_rdata, 32'h33);
        tick();
        chk("hit_noreq", mem_req, 0);

        // Conflict on index 0
        cpu_addr = 32'h100;
        #1;
        chk("conf_miss", cpu_hit, 0);
        refill(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0, -1, 1);
        chk("rdata_100", cpu_rdata, 32'hA0);
        cpu_addr = 32'h0;
        #1;
        chk("evicted_0", cpu_hit, 0);
        refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, -1, 1);
        chk("cnt_3", miss_count, 3);

        // Delayed ack with a stray rvalid during REQ
        cpu_addr = 32'h20;
        #1;
        refill(32'h20, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 5, 1, -1, 1);
        chk("rdata_20", cpu_rdata, 32'hB0);
        cpu_addr = 32'h2C;
        #1;
        chk("rdata_2c", cpu_rdata, 32'hB3);
        chk("cnt_4", miss_count, 4);

        // Flush during beat 2 leaves the line invalid and forces a re-miss
        cpu_addr = 32'h40;
        #1;
        refill(32'h40, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 0, 2, 0);
        refill(32'h40, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 0, -1, 1);
        chk("rdata_40", cpu_rdata, 32'hC0);
        chk("cnt_6", miss_count, 6);
        cpu_addr = 32'h0;
        #1;
        chk("flushed_0", cpu_hit, 0);
        refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, -1, 1);
        chk("cnt_7", miss_count, 7);

        // Async reset during beat 1
        cpu_addr = 32'h50;
        #1;
        tick();
        chk("r_req", mem_req, 1);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hD0;
        tick();
        mem_rdata = 32'hD1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_cnt", miss_count, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_hit", cpu_hit, 0);
        mem_rvalid = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_miss", cpu_hit, 0);
        refill(32'h50, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 0, -1, 1);
        chk("rdata_50", cpu_rdata, 32'hD0);
        cpu_addr = 32'h5C;
        #1;
        chk("rdata_5c", cpu_rdata, 32'hD3);
        chk("cnt_after_rst", miss_count, 1);
        cpu_addr = 32'h0;
        #1;
        chk("rst_inval_0", cpu_hit, 0);

        // Saturation: 16 more conflict misses push a 4-bit counter past 15
        for (int i = 0; i < 16; i++) begin
            cpu_addr = i[0] ? 32'h100 : 32'h0;
            #1;
            refill(cpu_addr, {4{i[31:0]}}, 0, 0, -1, 1);
            if (i == 13) chk("cnt_15", miss_count, 15);
        end
        chk("cnt_sat", miss_count, 4'hF);
        chk("sat_rdata", cpu_rdata, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
